// File: rtl/spi_mnrch.sv
`timescale 1ns/1ps
// spi_mnrch: 16-bit full-duplex SPI monarch driving the iNEMO inertial serf.
// Define SPI_MISO_SYNC_EN to route MISO through a 2-flop synchronizer.
module spi_mnrch #(
  parameter int unsigned SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int unsigned W        = SCLK_DIV_W;
  localparam int unsigned DW       = 16;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LD_INT   = (1 << W) - (1 << (W - 2)) - 1;
`ifdef SPI_MISO_SYNC_EN
  localparam int unsigned SMPL_INT = (1 << (W - 1)) + 1;
`else
  localparam int unsigned SMPL_INT = (1 << (W - 1)) - 1;
`endif
  localparam logic [W-1:0] DIV_LD   = W'(LD_INT);
  localparam logic [W-1:0] DIV_SMPL = W'(SMPL_INT);
  localparam logic [W-1:0] DIV_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_SHIFT_CNT = CNT_W'(14);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRONT = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] BACK  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     div_q, div_d;
  logic [DW-1:0]    shft_q, shft_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;
  logic             ss_n_q, ss_n_d;
  logic             miso_smpl_q, miso_smpl_d;
  logic             miso_in_c;
  logic             active_c;
  logic             smpl_c;
  logic             shft_c;

`ifdef SPI_MISO_SYNC_EN
  logic miso_ff1_q, miso_ff2_q;

  // MISO comes from another clock domain pin; resynchronize before sampling
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_ff1_q <= 1'b0;
      miso_ff2_q <= 1'b0;
    end else begin
      miso_ff1_q <= MISO;
      miso_ff2_q <= miso_ff1_q;
    end
  end

  assign miso_in_c = miso_ff2_q;
`else
  assign miso_in_c = MISO;
`endif

  assign active_c = (state_q != IDLE);
  assign smpl_c   = active_c && (div_q == DIV_SMPL);
  assign shft_c   = active_c && (div_q == DIV_ONES);

  // Outputs come straight off flops; div MSB idles at 1 so SCLK idles high
  assign done    = done_q;
  assign rd_data = shft_q;
  assign SS_n    = ss_n_q;
  assign SCLK    = div_q[W-1];
  assign MOSI    = shft_q[DW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= DIV_ONES;
      shft_q      <= '0;
      bit_cnt_q   <= '0;
      done_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      miso_smpl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      shft_q      <= shft_d;
      bit_cnt_q   <= bit_cnt_d;
      done_q      <= done_d;
      ss_n_q      <= ss_n_d;
      miso_smpl_q <= miso_smpl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    shft_d      = shft_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = done_q;
    ss_n_d      = ss_n_q;
    miso_smpl_d = miso_smpl_q;

    if (active_c) begin
      div_d = div_q + W'(1);
    end
    if (smpl_c) begin
      miso_smpl_d = miso_in_c;
    end

    case (state_q)
      IDLE: begin
        if (wrt) begin
          shft_d    = cmd;
          div_d     = DIV_LD;
          bit_cnt_d = '0;
          done_d    = 1'b0;
          ss_n_d    = 1'b0;
          state_d   = FRONT;
        end
      end
      FRONT: begin
        // First falling edge only launches cmd[15], which MOSI already holds
        if (shft_c) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shft_c) begin
          shft_d    = {shft_q[DW-2:0], miso_smpl_q};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_SHIFT_CNT) begin
            state_d = BACK;
          end
        end
      end
      BACK: begin
        // Final shift; pin divider high so no 17th falling edge appears
        if (shft_c) begin
          shft_d  = {shft_q[DW-2:0], miso_smpl_q};
          div_d   = DIV_ONES;
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_mnrch.sv
`timescale 1ns/1ps
// tb_spi_mnrch: randomized bench with a behavioural iNEMO serf and a register-level
// reference model for expected read data, frame timing and serf side effects.
module tb_spi_mnrch;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_mnrch #(.SCLK_DIV_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural iNEMO serf ----------------
  logic [7:0]  sreg [128];
  logic [15:0] s_rx;
  logic [15:0] s_tx;
  int          s_bits;
  int          s_falls;
  logic        miso_bit;
  logic        idle_noise;
  logic        int_flag;

  // Serf floats MISO while deselected; model that as noise
  always @(posedge clk) idle_noise <= 1'($urandom);
  assign MISO = SS_n ? idle_noise : miso_bit;

  initial begin
    logic ss_prev, sclk_prev;
    for (int i = 0; i < 128; i++) sreg[i] = 8'h00;
    sreg[7'h0F] = 8'h6A;
    sreg[7'h22] = 8'h3C;
    int_flag  = 1'b0;
    s_rx      = '0;
    s_tx      = '0;
    s_bits    = 0;
    s_falls   = 0;
    miso_bit  = 1'b0;
    ss_prev   = 1'b1;
    sclk_prev = 1'b1;
    forever begin
      @(SCLK or SS_n);
      if (SS_n !== ss_prev) begin
        if (!SS_n) begin
          s_rx = '0; s_tx = '0; s_bits = 0; s_falls = 0;
        end else if (s_bits == 16) begin
          if (!s_rx[15]) begin
            sreg[s_rx[14:8]] = s_rx[7:0];
            if (s_rx[14:8] == 7'h11 && s_rx[7:0] != 8'h00) int_flag = 1'b1;
          end else if (s_rx[14:8] == 7'h22) begin
            int_flag = 1'b0;
          end
        end
      end else if (!SS_n && SCLK && !sclk_prev && s_bits < 16) begin
        s_rx = {s_rx[14:0], MOSI};
        s_bits++;
        if (s_bits == 8) s_tx[7:0] = s_rx[7] ? sreg[s_rx[6:0]] : 8'hA5;
      end else if (!SS_n && !SCLK && sclk_prev && s_falls < 16) begin
        miso_bit = s_tx[15 - s_falls];
        s_falls++;
      end
      ss_prev   = SS_n;
      sclk_prev = SCLK;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [128];

  function automatic logic [15:0] exp_rd(input logic [15:0] c);
    return c[15] ? {8'h00, ref_mem[c[14:8]]} : 16'h00A5;
  endfunction

  // One transaction starting at a negedge; optional stray wrt and mid-frame reset
  task automatic run_txn(input logic [15:0] c, input int extra_n, input int rst_at);
    logic [15:0] exp;
    int n, ss_low, rises, falls, first_low;
    logic prev;
    exp = exp_rd(c);
    cmd = c;
    wrt = 1'b1;
    @(negedge clk);
    n = 0; ss_low = 0; rises = 0; falls = 0; first_low = -1; prev = 1'b1;
    forever begin
      wrt = (n == extra_n);
      if (n == extra_n) cmd = 16'($urandom);
      if (done) break;
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_eq("rst_mid_ss_n", 32'(SS_n), 32'd1);
        chk_eq("rst_mid_sclk", 32'(SCLK), 32'd1);
        chk_eq("rst_mid_done", 32'(done), 32'd0);
        chk_eq("rst_mid_rd_data", 32'(rd_data), 32'd0);
        chk_eq("rst_mid_mosi", 32'(MOSI), 32'd0);
        return;
      end
      if (n > 1500) begin
        chk_eq("done_timeout", 32'(n), 32'd521);
        return;
      end
      if (!SS_n) ss_low++;
      if (SCLK && !prev) rises++;
      if (!SCLK && prev) falls++;
      if (!SCLK && first_low < 0) first_low = n;
      prev = SCLK;
      @(negedge clk);
      n++;
    end
    chk_eq("done_latency", 32'(n), 32'd521);
    chk_eq("ss_low_clks", 32'(ss_low), 32'd521);
    chk_eq("sclk_rises", 32'(rises), 32'd16);
    chk_eq("sclk_falls", 32'(falls), 32'd16);
    chk_eq("front_porch", 32'(first_low), 32'd9);
    chk_eq("rd_data", 32'(rd_data), 32'(exp));
    chk_eq("serf_rx_cmd", 32'(s_rx), 32'(c));
    chk_eq("end_sclk_high", 32'(SCLK), 32'd1);
    chk_eq("end_ss_n_high", 32'(SS_n), 32'd1);
    if (!c[15]) ref_mem[c[14:8]] = c[7:0];
  endtask

  function automatic logic [15:0] rand_cmd();
    logic [6:0] a;
    a = 7'h30 + 7'($urandom_range(0, 15));
    return {1'($urandom), a, 8'($urandom)};
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    ref_mem[7'h0F] = 8'h6A;
    ref_mem[7'h22] = 8'h3C;
    rst = 1'b1; wrt = 1'b0; cmd = '0;
    repeat (3) @(negedge clk);

    // reset concurrent with wrt must win
    wrt = 1'b1; cmd = 16'h8F00;
    @(negedge clk);
    chk_eq("rst_wrt_ss_n", 32'(SS_n), 32'd1);
    rst = 1'b0; wrt = 1'b0;
    @(negedge clk);
    chk_eq("rst_wrt_ss_n_after", 32'(SS_n), 32'd1);
    chk_eq("reset_sclk", 32'(SCLK), 32'd1);
    chk_eq("reset_done", 32'(done), 32'd0);
    chk_eq("reset_rd_data", 32'(rd_data), 32'd0);
    chk_eq("reset_mosi", 32'(MOSI), 32'd0);

    // quiet idle
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cmd = 16'($urandom);
      @(negedge clk);
      if (!SCLK || !SS_n || done || rd_data != 16'h0000) bad++;
    end
    chk_eq("idle_quiet", 32'(bad), 32'd0);

    run_txn(16'h0D02, -1, -1);
    chk_eq("serf_reg_0d", 32'(sreg[7'h0D]), 32'h02);
    run_txn(16'h8F00, -1, -1);
    chk_eq("who_am_i", 32'(rd_data[7:0]), 32'h6A);
    run_txn(16'h1160, -1, -1);
    chk_eq("int_set", 32'(int_flag), 32'd1);
    run_txn(16'hA200, -1, -1);
    chk_eq("pitch_lo", 32'(rd_data[7:0]), 32'h3C);
    chk_eq("int_clear", 32'(int_flag), 32'd0);

    // stray wrt mid-frame and on the done edge are both ignored
    run_txn(rand_cmd(), 100, -1);
    run_txn(rand_cmd(), 520, -1);
    @(negedge clk);
    chk_eq("wrt_on_done_ss_n", 32'(SS_n), 32'd1);
    chk_eq("wrt_on_done_done", 32'(done), 32'd1);

    // back-to-back random traffic, next wrt on the first idle cycle
    for (int i = 0; i < 12; i++) run_txn(rand_cmd(), -1, -1);

    // reset mid-frame, then a clean read
    run_txn({1'b0, 7'h31, 8'h99}, -1, 200);
    run_txn(16'h8F00, -1, -1);
    chk_eq("post_rst_who_am_i", 32'(rd_data), 32'h006A);
    run_txn({1'b1, 7'h31, 8'h00}, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mnrch.md
Name: spi_mnrch

Overview:
- 16-bit SPI monarch (master) that drives the iNEMO inertial sensor serf.
- Sits between the inertial interface state machine and the sensor pins.
- Each `wrt` runs one full-duplex 16-bit transaction: `cmd` is shifted out on MOSI and the returned word is captured from MISO.
- Serf contract: it samples MOSI on rising SCLK and changes MISO on falling SCLK. SCLK idles high and SS_n is active low.

Parameters:
- SCLK_DIV_W, default 5: width of the SCLK divider. SCLK period = 2^SCLK_DIV_W clk (32). Legal range 4..8.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- wrt  input  1  single-clk pulse that starts a transaction with `cmd`
- cmd  input  16  command/data word, MSB first; bit15 = R/Wn, bits14:8 = address, bits7:0 = write data
- done  output  1  transaction complete; held high until next accepted wrt
- rd_data  output  16  word received over the transaction
- SS_n  output  1  serf select, active low
- SCLK  output  1  serial clock
- MOSI  output  1  serial data to serf; always equal to shft_reg[15]
- MISO  input  1  serial data from serf

Behaviour:
- Reset (rst high at a clk edge, including mid-transaction):
  - state = IDLE, SS_n = 1, SCLK = 1, done = 0.
  - shft_reg = 0, so rd_data = 0 and MOSI = 0. Divider = all ones, bit_cnt = 0.
- Divider `div` (SCLK_DIV_W bits):
  - Counts +1 every clk while state != IDLE.
  - SCLK = div[MSB] while active; SCLK = 1 in IDLE.
  - Load value LD = 2^W − 2^(W−2) − 1, which is 23 for W=5. This gives a front porch of 9 clk with SCLK high before the first fall.
- Events, each acting on the clk edge where the condition holds:
  - smpl: div == 2^(W−1)−1 (15), i.e. SCLK about to rise. Action: miso_smpl <= MISO.
  - shft: div == all ones (31), i.e. SCLK about to fall.
- State machine states: IDLE, FRONT, SHIFT, BACK.
  - IDLE:
    - On wrt: shft_reg <= cmd, div <= LD, bit_cnt <= 0, done <= 0, SS_n <= 0, go to FRONT.
    - Otherwise hold.
  - FRONT:
    - On the first shft event: no shift; MOSI already holds cmd[15]. Go to SHIFT.
  - SHIFT:
    - Each shft event: shft_reg <= {shft_reg[14:0], miso_smpl}, bit_cnt++.
    - When bit_cnt reaches 15, go to BACK.
  - BACK:
    - smpl of the 16th rising edge occurs normally.
    - At the next shft event: final shift (16 bits total), div <= all ones so SCLK stays high with no 17th falling edge.
    - Same edge: SS_n <= 1, done <= 1, go to IDLE.
- Output timing:
  - rd_data = shft_reg. It is valid when done = 1 and holds until the next wrt.
- Latency (W=5):
  - SS_n falls on the edge that samples wrt (edge 0).
  - First SCLK fall occurs after edge 9.
  - 16 rising SCLK edges occur.
  - done and SS_n rise on edge 521.
  - SS_n low for exactly 521 clk.
- Boundary conditions:
  - wrt while state != IDLE: ignored.
  - wrt on the same edge done rises: ignored, because state is not yet IDLE.
  - wrt on any later IDLE cycle: accepted. Back-to-back transactions give ≥1 clk of SS_n high.
  - rst concurrent with wrt: reset wins.
  - MISO is not required to be valid while SS_n = 1 (tri-state from serf).

Optional Feature:
- Macro SPI_MISO_SYNC_EN.
- Defined:
  - MISO passes through a 2-flop synchronizer before use.
  - The smpl event moves to div == 2^(W−1)+1, two clk after SCLK rises, so the captured bit matches the value present at the rising edge.
  - Total latency unchanged.
- Undefined: MISO is sampled directly at div == 2^(W−1)−1.

Test Plan:
- Reset, then hold idle 100 clk -> SS_n=1, SCLK=1, done=0, rd_data=0x0000, no SCLK toggles.
- wrt with cmd=0x0D02 to iNEMO model (after its POR) -> exactly 16 rising SCLK while SS_n low; done rises 521 clk after wrt; rd_data=0x00A5; model register 0x0D = 0x02.
- wrt cmd=0x8F00 (WHO_AM_I read) -> rd_data[7:0]=0x6A. Then write 0x1160 -> model begins asserting INT.
- After INT, wrt cmd=0xA200 -> rd_data[7:0] = pitch low byte of inert_data entry 0, and INT clears.
- Pulse wrt again 100 clk into a transaction -> ignored; single transaction completes with correct rd_data, SS_n low 521 clk.
- Assert rst at clk 200 of a transaction -> next edge: SS_n=1, SCLK=1, done=0, rd_data=0. A following wrt cmd=0x8F00 returns 0x6A.
